// File: rtl/mfe_lcd_pkg.sv
// Shared constants, beat payload and FSM encoding for the LCD text sequencer.
package mfe_lcd_pkg;

  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] CHAR_SPACE    = 8'h20;

  // DDRAM start address of each display row, indexed by row number
  localparam logic [3:0][7:0] ROW_BASE = {8'h54, 8'h14, 8'h40, 8'h00};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_CHAR = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic       cmd;
    logic [7:0] dat;
  } beat_t;

  function automatic logic [7:0] addr_cmd(input logic [1:0] row);
    return CMD_SET_DDRAM | ROW_BASE[row];
  endfunction

endpackage

// File: rtl/mfe_lcd_text_buf.sv
// ROWS x COLS character store: one write port, one async read port, resets to spaces.
module mfe_lcd_text_buf
  import mfe_lcd_pkg::*;
#(
  parameter int unsigned ROWS = 2,
  parameter int unsigned COLS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_row,
  input  logic [5:0] wr_col,
  input  logic [7:0] wr_data,
  input  logic [1:0] rd_row,
  input  logic [5:0] rd_col,
  output logic [7:0] rd_data_c
);

  localparam int unsigned DEPTH = ROWS * COLS;
  localparam int unsigned AW    = $clog2(DEPTH);

  function automatic logic [AW-1:0] idx(input logic [1:0] r, input logic [5:0] c);
    return AW'(32'(r) * COLS + 32'(c));
  endfunction

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];

  // Caller only asserts wr_en for in-range coordinates
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[idx(wr_row, wr_col)] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= CHAR_SPACE;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data_c = mem_q[idx(rd_row, rd_col)];

endmodule

// File: rtl/mfe_lcd_text_sequencer.sv
// Streams the text buffer to an LCD controller wrapper as address-set commands and characters.
module mfe_lcd_text_sequencer
  import mfe_lcd_pkg::*;
#(
  parameter int unsigned ROWS         = 2,
  parameter int unsigned COLS         = 16,
  parameter int unsigned AUTO_REFRESH = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_row,
  input  logic [5:0] wr_col,
  input  logic [7:0] wr_data,
  input  logic       update,
  input  logic       ready,
  output logic [7:0] dat,
  output logic       cmd,
  output logic       vld,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);
  localparam logic [5:0] LAST_COL = 6'(COLS - 1);

  state_e     state_q, state_d;
  logic [1:0] row_q, row_d;
  logic [5:0] col_q, col_d;
  logic       pending_q, pending_d;
  beat_t      beat_q, beat_d;
  logic       vld_q, vld_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;

  logic       wr_ok_c, req_c, accept_c;
  logic [1:0] rd_row_c;
  logic [5:0] rd_col_c;
  logic [7:0] rd_data_c, char_c;

  assign wr_ok_c  = wr_en && (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
  assign req_c    = update || ((AUTO_REFRESH != 0) && wr_ok_c);
  assign accept_c = vld_q && ready;

  // Position of the character loaded on the next acceptance
  always_comb begin
    rd_row_c = row_q;
    rd_col_c = (state_q == ST_ADDR) ? 6'd0 : col_q + 6'd1;
  end

  mfe_lcd_text_buf #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_text_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_ok_c),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .rd_row    (rd_row_c),
    .rd_col    (rd_col_c),
    .rd_data_c (rd_data_c)
  );

  // Forward a same-cycle write so the frame never shows a stale character
  assign char_c = (wr_ok_c && (wr_row == rd_row_c) && (wr_col == rd_col_c)) ? wr_data : rd_data_c;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    pending_d    = pending_q;
    beat_d       = beat_q;
    vld_d        = vld_q;
    frame_done_d = 1'b0;

    if ((state_q != ST_IDLE) && req_c) pending_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (req_c || pending_q) begin
          state_d   = ST_ADDR;
          row_d     = 2'd0;
          col_d     = 6'd0;
          pending_d = 1'b0;
          vld_d     = 1'b1;
          beat_d    = '{cmd: 1'b1, dat: addr_cmd(2'd0)};
        end
      end
      ST_ADDR: begin
        if (accept_c) begin
          state_d = ST_CHAR;
          beat_d  = '{cmd: 1'b0, dat: char_c};
        end
      end
      ST_CHAR: begin
        if (accept_c) begin
          if (col_q == LAST_COL) begin
            col_d = 6'd0;
            if (row_q == LAST_ROW) begin
              state_d      = ST_DONE;
              vld_d        = 1'b0;
              frame_done_d = 1'b1;
            end else begin
              state_d = ST_ADDR;
              row_d   = row_q + 2'd1;
              beat_d  = '{cmd: 1'b1, dat: addr_cmd(row_q + 2'd1)};
            end
          end else begin
            col_d  = col_q + 6'd1;
            beat_d = '{cmd: 1'b0, dat: char_c};
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      row_q        <= 2'd0;
      col_q        <= 6'd0;
      pending_q    <= 1'b0;
      beat_q       <= '{cmd: 1'b0, dat: CHAR_SPACE};
      vld_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      pending_q    <= pending_d;
      beat_q       <= beat_d;
      vld_q        <= vld_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dat        = beat_q.dat;
  assign cmd        = beat_q.cmd;
  assign vld        = vld_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mfe_lcd_text_sequencer.sv
// Directed bench: a 2x16 manual-update instance and a 4x20 auto-refresh instance.
module tb_mfe_lcd_text_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Instance A: 2 rows x 16 cols, manual update
  logic       a_wr_en, a_update, a_ready;
  logic [1:0] a_wr_row;
  logic [5:0] a_wr_col;
  logic [7:0] a_wr_data, a_dat;
  logic       a_cmd, a_vld, a_busy, a_fd;

  mfe_lcd_text_sequencer #(.ROWS(2), .COLS(16), .AUTO_REFRESH(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(a_wr_en), .wr_row(a_wr_row), .wr_col(a_wr_col),
    .wr_data(a_wr_data), .update(a_update), .ready(a_ready), .dat(a_dat), .cmd(a_cmd),
    .vld(a_vld), .busy(a_busy), .frame_done(a_fd)
  );

  // Instance B: 4 rows x 20 cols, auto refresh
  logic       b_wr_en, b_update, b_ready;
  logic [1:0] b_wr_row;
  logic [5:0] b_wr_col;
  logic [7:0] b_wr_data, b_dat;
  logic       b_cmd, b_vld, b_busy, b_fd;

  mfe_lcd_text_sequencer #(.ROWS(4), .COLS(20), .AUTO_REFRESH(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_row(b_wr_row), .wr_col(b_wr_col),
    .wr_data(b_wr_data), .update(b_update), .ready(b_ready), .dat(b_dat), .cmd(b_cmd),
    .vld(b_vld), .busy(b_busy), .frame_done(b_fd)
  );

  logic [8:0] a_beats[$];
  logic [8:0] b_beats[$];
  int         a_fd_cnt = 0;
  int         b_fd_cnt = 0;
  logic       a_hold = 1'b0;
  logic [9:0] a_hold_val = '0;
  logic       a_tog = 1'b0;
  logic [7:0] a_model [2][16];
  logic [7:0] row_base [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

  // Record accepted beats and done pulses; check output stability while stalled
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_hold) check_val("a_hold_stable", 32'({a_vld, a_cmd, a_dat}), 32'(a_hold_val));
      if (a_vld && a_ready) a_beats.push_back({a_cmd, a_dat});
      if (a_fd) a_fd_cnt++;
      if (b_vld && b_ready) b_beats.push_back({b_cmd, b_dat});
      if (b_fd) b_fd_cnt++;
    end
    a_hold     = rst_n && a_vld && !a_ready;
    a_hold_val = {a_vld, a_cmd, a_dat};
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (a_tog) a_ready = ~a_ready;
  endtask

  task automatic a_clear();
    a_beats.delete();
    a_fd_cnt = 0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 16; c++) a_model[r][c] = 8'h20;
  endtask

  task automatic a_write(input logic [1:0] r, input logic [5:0] c, input logic [7:0] d);
    a_wr_en = 1'b1; a_wr_row = r; a_wr_col = c; a_wr_data = d;
    tick();
    a_wr_en = 1'b0;
    if (r < 2'd2 && c < 6'd16) a_model[r][c] = d;
  endtask

  task automatic b_write(input logic [1:0] r, input logic [5:0] c, input logic [7:0] d);
    b_wr_en = 1'b1; b_wr_row = r; b_wr_col = c; b_wr_data = d;
    tick();
    b_wr_en = 1'b0;
  endtask

  task automatic a_pulse_update();
    a_update = 1'b1;
    tick();
    a_update = 1'b0;
  endtask

  task automatic a_wait_fd(input int target, input int budget, input string tag);
    int n = 0;
    while (a_fd_cnt < target && n < budget) begin tick(); n++; end
    if (a_fd_cnt < target) check_val({tag, "_timeout"}, 32'(a_fd_cnt), 32'(target));
    repeat (2) tick();
  endtask

  task automatic b_wait_fd(input int target, input int budget, input string tag);
    int n = 0;
    while (b_fd_cnt < target && n < budget) begin tick(); n++; end
    if (b_fd_cnt < target) check_val({tag, "_timeout"}, 32'(b_fd_cnt), 32'(target));
    repeat (2) tick();
  endtask

  // Compare captured A frame with the frame implied by the bench's buffer model
  task automatic check_frame_a(input string tag);
    logic [8:0] exp[$];
    int mism = 0;
    for (int r = 0; r < 2; r++) begin
      exp.push_back({1'b1, 8'h80 | row_base[r]});
      for (int c = 0; c < 16; c++) exp.push_back({1'b0, a_model[r][c]});
    end
    check_val({tag, "_len"}, 32'(a_beats.size()), 32'd34);
    for (int i = 0; i < 34; i++)
      if (i >= a_beats.size() || a_beats[i] !== exp[i]) mism++;
    check_val({tag, "_content_mismatches"}, 32'(mism), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_wr_en = 1'b0; a_wr_row = '0; a_wr_col = '0; a_wr_data = '0; a_update = 1'b0; a_ready = 1'b1;
    b_wr_en = 1'b0; b_wr_row = '0; b_wr_col = '0; b_wr_data = '0; b_update = 1'b0; b_ready = 1'b1;
    model_reset();
    repeat (3) tick();
    check_val("rst_vld",  32'(a_vld),  32'd0);
    check_val("rst_cmd",  32'(a_cmd),  32'd0);
    check_val("rst_dat",  32'(a_dat),  32'h20);
    check_val("rst_busy", 32'(a_busy), 32'd0);
    check_val("rst_fd",   32'(a_fd),   32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    check_val("idle_no_beats", 32'(a_beats.size()), 32'd0);

    // Default buffer, ready held high
    a_clear();
    a_pulse_update();
    check_val("t1_busy", 32'(a_busy), 32'd1);
    a_wait_fd(1, 100, "t1");
    check_frame_a("t1");
    check_val("t1_beat0",  32'(a_beats[0]),  32'h180);
    check_val("t1_beat1",  32'(a_beats[1]),  32'h020);
    check_val("t1_beat17", 32'(a_beats[17]), 32'h1C0);
    repeat (5) tick();
    check_val("t1_fd_once", 32'(a_fd_cnt), 32'd1);
    check_val("t1_idle",    32'(a_busy),   32'd0);

    // "Hi" on row 1 with ready toggling every cycle
    a_write(2'd1, 6'd0, 8'h48);
    a_write(2'd1, 6'd1, 8'h69);
    a_clear();
    a_tog = 1'b1;
    a_pulse_update();
    a_wait_fd(1, 200, "t2");
    a_tog = 1'b0;
    a_ready = 1'b1;
    check_frame_a("t2");
    check_val("t2_beat17", 32'(a_beats[17]), 32'h1C0);
    check_val("t2_beat18", 32'(a_beats[18]), 32'h048);
    check_val("t2_beat19", 32'(a_beats[19]), 32'h069);

    // Write together with update, plus a write ahead of the read pointer
    a_clear();
    a_wr_en = 1'b1; a_wr_row = 2'd0; a_wr_col = 6'd0; a_wr_data = 8'h41; a_update = 1'b1;
    tick();
    a_wr_en = 1'b0; a_update = 1'b0;
    a_model[0][0] = 8'h41;
    repeat (3) tick();
    a_write(2'd1, 6'd5, 8'h5A);
    a_wait_fd(1, 100, "t3");
    check_frame_a("t3");
    check_val("t3_same_cycle_wr", 32'(a_beats[1]),  32'h041);
    check_val("t3_inflight_wr",   32'(a_beats[23]), 32'h05A);

    // Three extra requests during a frame collapse into one more frame
    a_clear();
    a_pulse_update();
    repeat (5) tick();
    a_pulse_update();
    repeat (10) tick();
    a_pulse_update();
    repeat (3) tick();
    a_pulse_update();
    a_wait_fd(2, 300, "t4");
    repeat (60) tick();
    check_val("t4_fd_count", 32'(a_fd_cnt), 32'd2);
    check_val("t4_beats",    32'(a_beats.size()), 32'd68);

    // Reset in the middle of a frame
    a_clear();
    a_pulse_update();
    begin
      int n = 0;
      while (a_beats.size() < 10 && n < 50) begin tick(); n++; end
    end
    check_val("t5_reach_beat10", 32'(a_beats.size()), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    check_val("t5_async_vld",  32'(a_vld),  32'd0);
    check_val("t5_async_busy", 32'(a_busy), 32'd0);
    check_val("t5_async_dat",  32'(a_dat),  32'h20);
    repeat (2) tick();
    rst_n = 1'b1;
    model_reset();
    repeat (40) tick();
    check_val("t5_no_fd",    32'(a_fd_cnt), 32'd0);
    check_val("t5_no_beats", 32'(a_beats.size()), 32'd10);
    a_clear();
    a_pulse_update();
    a_wait_fd(1, 100, "t5b");
    check_frame_a("t5_buffer_cleared");

    // Out-of-range writes are dropped
    a_write(2'd0, 6'd16, 8'h58);
    a_write(2'd2, 6'd0,  8'h59);
    a_clear();
    a_pulse_update();
    a_wait_fd(1, 100, "t6");
    check_frame_a("t6");
    check_val("t6_no_alias", 32'(a_beats[18]), 32'h020);

    // Auto-refresh instance: a write starts a 4x20 frame
    b_beats.delete();
    b_fd_cnt = 0;
    b_write(2'd0, 6'd3, 8'h51);
    b_wait_fd(1, 200, "t7");
    check_val("t7_len",    32'(b_beats.size()), 32'd84);
    check_val("t7_addr0",  32'(b_beats[0]),  32'h180);
    check_val("t7_addr1",  32'(b_beats[21]), 32'h1C0);
    check_val("t7_addr2",  32'(b_beats[42]), 32'h194);
    check_val("t7_addr3",  32'(b_beats[63]), 32'h1D4);
    check_val("t7_beat4",  32'(b_beats[4]),  32'h051);
    check_val("t7_beat5",  32'(b_beats[5]),  32'h020);
    b_write(2'd0, 6'd20, 8'h52);
    repeat (50) tick();
    check_val("t8_no_auto_fd", 32'(b_fd_cnt), 32'd1);
    check_val("t8_no_beats",   32'(b_beats.size()), 32'd84);
    check_val("t8_idle",       32'(b_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
